// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller beside the M stage: SR, Cause, EPC, PRId plus trap arbitration.
// Latency: req/redirect_pc/cp0_rdata are combinational on current state; register updates are visible one cycle after the edge.
// Backpressure: none; a taken trap flushes F..M, and any mtc0/eret in the trapping slot is dropped.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset (clears SR/Cause/EPC)
//   m_pc, m_valid, m_bd M-stage slot PC, valid flag and branch-delay-slot flag
//   m_exccode           exception code carried into M (0 = none)
//   hw_int              level-sensitive external interrupt lines
//   cp0_we/addr/wdata   mtc0 in M; cp0_addr also selects the mfc0 read
//   eret                eret in M
//   cp0_rdata           mfc0 read data (unregistered, pre-edge values)
//   epc_out             current EPC
//   req                 trap taken this cycle
//   redirect_pc         handler entry when req, otherwise EPC (eret target)
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL  = 32'h2025_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_pc,
    input  logic        m_valid,
    input  logic        m_bd,
    input  logic [4:0]  m_exccode,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        eret,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic        req,
    output logic [31:0] redirect_pc
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;

    // Cause fields
    logic        bd_q,      bd_d;
    logic [5:0]  ip_q,      ip_d;
    logic [4:0]  exccode_q, exccode_d;

    // EPC: only bits [31:2] are stored; [1:0] always read as zero
    logic [29:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] trap_pc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;

    // ------------------------------------------------------------------
    // Register views
    // ------------------------------------------------------------------
    assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};
    assign epc_val   = {epc_q, 2'b00};
    assign epc_out   = epc_val;

    // ------------------------------------------------------------------
    // Trap arbitration; EXL masks both sources so a handler cannot nest
    // ------------------------------------------------------------------
    assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_req = m_valid & (m_exccode != 5'd0) & ~exl_q;
    assign req     = int_req | exc_req;

    assign redirect_pc = req ? EXC_ENTRY : epc_val;

    // A delay-slot instruction restarts at its branch so the branch re-executes
    assign trap_pc = m_bd ? (m_pc - 32'd4) : m_pc;

    // ------------------------------------------------------------------
    // mfc0 read mux (no write-to-read bypass; hazard unit stalls instead)
    // ------------------------------------------------------------------
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = sr_val;
            ADDR_CAUSE: cp0_rdata = cause_val;
            ADDR_EPC:   cp0_rdata = epc_val;
            ADDR_PRID:  cp0_rdata = PRID_VAL;
            default:    cp0_rdata = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        // IP mirrors the pins every cycle, trap or not; software never writes it
        ip_d      = hw_int;

        if (req) begin
            // Trapping slot is flushed: its mtc0/eret must not take effect
            exl_d     = 1'b1;
            bd_d      = m_bd;
            exccode_d = int_req ? 5'd0 : m_exccode;
            epc_d     = trap_pc[31:2];
        end else begin
            if (cp0_we) begin
                if (cp0_addr == ADDR_SR) begin
                    im_d  = cp0_wdata[15:10];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end else if (cp0_addr == ADDR_EPC) begin
                    epc_d = cp0_wdata[31:2];
                end
            end
            // Placed after the mtc0 so eret's EXL clear wins a same-cycle SR write
            if (eret) begin
                exl_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 30'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expected values.
// Latency: inputs driven 1 time unit after posedge, outputs sampled mid-cycle.
// Backpressure: none.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_bd;
    logic [4:0]  m_exccode;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        req;
    logic [31:0] redirect_pc;

    int n_total = 0;
    int n_bad   = 0;

    cp0_exc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .m_pc        (m_pc),
        .m_valid     (m_valid),
        .m_bd        (m_bd),
        .m_exccode   (m_exccode),
        .hw_int      (hw_int),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .eret        (eret),
        .cp0_rdata   (cp0_rdata),
        .epc_out     (epc_out),
        .req         (req),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we    = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
        tick();
        cp0_we    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        m_pc      = 32'd0;
        m_valid   = 1'b0;
        m_bd      = 1'b0;
        m_exccode = 5'd0;
        hw_int    = 6'd0;
        cp0_we    = 1'b0;
        cp0_addr  = 5'd0;
        cp0_wdata = 32'd0;
        eret      = 1'b0;
        #2;

        // 1. Reset state
        rd_chk("rst_sr",    5'd12, 32'h0000_0000);
        rd_chk("rst_cause", 5'd13, 32'h0000_0000);
        rd_chk("rst_epc",   5'd14, 32'h0000_0000);
        rd_chk("rst_prid",  5'd15, 32'h2025_0007);
        rd_chk("rst_other", 5'd3,  32'h0000_0000);
        chk("rst_req", {31'd0, req}, 32'd0);
        tick();
        reset = 1'b0;

        // 2. Enable IM0+IE, then raise hw_int[0]
        mtc0(5'd12, 32'h0000_0401);
        rd_chk("mtc0_sr", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        m_pc   = 32'h0000_2000;
        #1;
        chk("int_req", {31'd0, req}, 32'd1);
        chk("int_redir", redirect_pc, 32'h0000_4180);
        tick();
        hw_int = 6'd0;
        rd_chk("int_sr",    5'd12, 32'h0000_0403);
        rd_chk("int_cause", 5'd13, 32'h0000_0400);
        rd_chk("int_epc",   5'd14, 32'h0000_2000);
        chk("int_exl_mask", {31'd0, req}, 32'd0);

        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd_chk("eret1_sr", 5'd12, 32'h0000_0401);

        // 3. RI exception in a delay slot
        m_valid   = 1'b1;
        m_exccode = 5'd10;
        m_pc      = 32'h0000_3010;
        m_bd      = 1'b1;
        #1;
        chk("exc_req", {31'd0, req}, 32'd1);
        tick();
        m_valid   = 1'b0;
        m_exccode = 5'd0;
        m_bd      = 1'b0;
        rd_chk("exc_epc",   5'd14, 32'h0000_300C);
        rd_chk("exc_cause", 5'd13, 32'h8000_0028);
        rd_chk("exc_sr",    5'd12, 32'h0000_0403);

        // 4. EXL=1 masks everything; IP still tracks the pins
        m_valid   = 1'b1;
        m_exccode = 5'd4;
        hw_int    = 6'b000001;
        m_pc      = 32'h0000_3300;
        #1;
        chk("nest_req", {31'd0, req}, 32'd0);
        chk("nest_redir", redirect_pc, 32'h0000_300C);
        tick();
        m_valid   = 1'b0;
        m_exccode = 5'd0;
        rd_chk("nest_epc",   5'd14, 32'h0000_300C);
        rd_chk("nest_cause", 5'd13, 32'h8000_0428);

        // 5. mtc0 EPC with low bits set, then eret
        hw_int = 6'd0;
        mtc0(5'd14, 32'h0000_3057);
        chk("mtc0_epc_out", epc_out, 32'h0000_3054);
        chk("eret_redir", redirect_pc, 32'h0000_3054);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd_chk("eret2_sr", 5'd12, 32'h0000_0401);

        // Writes to Cause and PRId are ignored
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'hFFFF_FFFF);
        rd_chk("ro_cause", 5'd13, 32'h8000_0028);
        rd_chk("ro_prid",  5'd15, 32'h2025_0007);

        // Same-cycle mtc0 SR (EXL=1) and eret: eret clears EXL
        eret = 1'b1;
        mtc0(5'd12, 32'h0000_0803);
        eret = 1'b0;
        rd_chk("sr_eret_win", 5'd12, 32'h0000_0801);
        mtc0(5'd12, 32'h0000_0401);

        // Interrupt in a bubble beats a stale exception code; EPC low bits cleared
        m_valid   = 1'b0;
        m_exccode = 5'd5;
        hw_int    = 6'b000001;
        m_pc      = 32'h0000_3202;
        #1;
        chk("bub_req", {31'd0, req}, 32'd1);
        tick();
        hw_int    = 6'd0;
        m_exccode = 5'd0;
        rd_chk("bub_epc",   5'd14, 32'h0000_3200);
        rd_chk("bub_cause", 5'd13, 32'h0000_0400);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // Exception code on a bubble is not taken
        m_exccode = 5'd8;
        #1;
        chk("bub_exc_noreq", {31'd0, req}, 32'd0);

        // 6. Exception with a same-cycle mtc0 EPC: the mtc0 is dropped
        m_valid   = 1'b1;
        m_pc      = 32'h0000_3100;
        cp0_we    = 1'b1;
        cp0_addr  = 5'd14;
        cp0_wdata = 32'h0000_5000;
        #1;
        chk("t6_req", {31'd0, req}, 32'd1);
        tick();
        cp0_we    = 1'b0;
        m_valid   = 1'b0;
        m_exccode = 5'd0;
        rd_chk("t6_epc",   5'd14, 32'h0000_3100);
        rd_chk("t6_cause", 5'd13, 32'h0000_0020);

        // Asynchronous reset mid-cycle
        #1;
        reset = 1'b1;
        #1;
        chk("arst_epc", epc_out, 32'h0000_0000);
        rd_chk("arst_sr",    5'd12, 32'h0000_0000);
        rd_chk("arst_cause", 5'd13, 32'h0000_0000);

        // Reset held through a req cycle: trap not recorded
        m_valid   = 1'b1;
        m_exccode = 5'd12;
        m_pc      = 32'h0000_3400;
        tick();
        chk("rst_req_epc", epc_out, 32'h0000_0000);
        rd_chk("rst_req_cause", 5'd13, 32'h0000_0000);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
